// File: rtl/serial_frame_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_pkg
// Shared types and constants for the serial frame receiver.
//   rx_state_e : framing FSM state (IDLE, DATA, PARITY, STOP)
//   START_BIT  : line value that opens a frame
//   STOP_BIT   : line value that must close a frame
// -----------------------------------------------------------------------------
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage : serial_frame_pkg

// File: rtl/serial_frame_rx_out_reg.sv
// -----------------------------------------------------------------------------
// frame_out_reg
// Single-entry valid/ready holding register for decoded words.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : a good frame finished this cycle
//   push_data_i  : the decoded word of that frame
//   pop_i        : consumer ready (accepts when valid_o && pop_i)
//   data_o       : held word, stable while valid_o=1, kept after a pop
//   valid_o      : word available
//   overrun_o    : one-cycle pulse, a good frame was dropped because the
//                  register was full and not being popped
//
// Handshake: a word transfers on every rising edge where valid_o && pop_i.
// A push in the same cycle as a pop refills the register with no gap.
// -----------------------------------------------------------------------------
module frame_out_reg
    import serial_frame_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (push_i) begin
            // Room exists if empty, or if the current word leaves this cycle.
            if (!valid_q || pop_i) begin
                data_d  = push_data_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule : frame_out_reg

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
// Decodes framed words from a strobed serial bit stream:
//   start(1), DATA_W data bits LSB first, optional even parity, stop(0).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit_in       : serial bit, consumed only when bit_valid=1
//   bit_valid    : per-bit strobe
//   out_data     : decoded word, stable while out_valid=1
//   out_valid    : word available
//   out_ready    : consumer accepts when out_valid && out_ready
//   parity_err   : one-cycle pulse, frame discarded for bad parity
//   frame_err    : one-cycle pulse, frame discarded for bad stop bit
//   overrun      : one-cycle pulse, good frame dropped (register full)
//   dbg_state_o  : current framing FSM state, for observation only
// All outputs are registered; pulses appear the cycle after the stop bit
// is sampled, together with out_valid.
// -----------------------------------------------------------------------------
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output rx_state_e         dbg_state_o
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, frame_err_q;

    // Per-frame verdicts, only ever asserted on the stop-bit cycle.
    logic frame_good, stop_bad, par_fail;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (bit_valid) begin
            case (state_q)
                IDLE:    if (bit_in == START_BIT) state_d = DATA;
                DATA:    if (cnt_q == LAST_IDX) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  state_d = STOP;
                // A bad stop bit returns to IDLE as well, so it is never
                // mistaken for the start of the next frame.
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    // Stop-bit error wins over parity error, so each frame yields at most
    // one error pulse.
    always_comb begin
        frame_good = 1'b0;
        stop_bad   = 1'b0;
        par_fail   = 1'b0;
        if (bit_valid && state_q == STOP) begin
            if (bit_in != STOP_BIT) begin
                stop_bad = 1'b1;
            end else if (par_bad_q) begin
                par_fail = 1'b1;
            end else begin
                frame_good = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ datapath
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (bit_in == START_BIT) begin
                        cnt_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = bit_in;
                    cnt_d          = cnt_q + 1'b1;
                end
                // Even parity: data bits XOR parity bit must be zero.
                PARITY:  par_bad_d = (^shift_q) ^ bit_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= par_fail;
            frame_err_q  <= stop_bad;
        end
    end

    // --------------------------------------------------- holding register
    frame_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (frame_good),
        .push_data_i (shift_q),
        .pop_i       (out_ready),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .overrun_o   (overrun)
    );

    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

endmodule : serial_frame_rx

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
// Bench for serial_frame_rx: a PARITY_EN=1 instance exercised against a
// frame-level reference model, and a PARITY_EN=0 instance for the short frame.
// Inputs change 2 time units after a rising edge; outputs are read on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    logic       clk, rst_n;
    logic       bit_in, bit_valid, out_ready;
    logic [7:0] out_data;
    logic       out_valid, parity_err, frame_err, overrun;
    rx_state_e  dbg_state;

    logic       bit_in2, bit_valid2, out_ready2;
    logic [7:0] out_data2;
    logic       out_valid2, parity_err2, frame_err2, overrun2;
    rx_state_e  dbg_state2;

    int checks   = 0;
    int failures = 0;

    // Reference model: holding register contents and expected pulses.
    logic       m_valid;
    logic [7:0] m_data;
    logic       e_par, e_frm, e_ovr;
    logic       ready_level;
    logic [7:0] exp_q[$];

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .dbg_state_o(dbg_state)
    );

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(0)) dut_np (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in2), .bit_valid(bit_valid2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .parity_err(parity_err2), .frame_err(frame_err2), .overrun(overrun2),
        .dbg_state_o(dbg_state2)
    );

    // ------------------------------------------------------ clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

    // ------------------------------------------------------------ drivers
    task automatic drive(input logic v, input logic b, input logic r);
        @(posedge clk);
        #2;
        bit_valid = v;
        bit_in    = b;
        out_ready = r;
    endtask

    task automatic drive2(input logic v, input logic b);
        @(posedge clk);
        #2;
        bit_valid2 = v;
        bit_in2    = b;
    endtask

    // Drives one full 11-bit frame; the stop bit is left on the line, not yet
    // sampled. Gap cycles carry random junk on bit_in.
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_val,
                              input int max_gap, input bit ready_at_stop);
        logic bits[$];
        int   gaps;
        bits.push_back(1'b1);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        bits.push_back((^d) ^ par_flip);
        bits.push_back(stop_val);
        foreach (bits[i]) begin
            gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gaps; g++) drive(1'b0, 1'($urandom), ready_level);
            if (i == bits.size() - 1) drive(1'b1, bits[i], ready_level | ready_at_stop);
            else                      drive(1'b1, bits[i], ready_level);
        end
    endtask

    // Lets the stop bit be sampled, then parks at the falling edge where the
    // frame's result is visible.
    task automatic finish_frame;
        drive(1'b0, 1'b0, ready_level);
        @(negedge clk);
    endtask

    task automatic do_pop;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    // Frame-level rules: stop must be 0, parity must be even, a good frame
    // lands only if the register is empty or being emptied.
    task automatic model_frame(input logic [7:0] d, input bit par_flip, input bit stop_val,
                               input bit ready);
        e_frm = stop_val;
        e_par = !stop_val && par_flip;
        e_ovr = 1'b0;
        if (!stop_val && !par_flip) begin
            if (m_valid && !ready) e_ovr = 1'b1;
            else begin
                m_valid = 1'b1;
                m_data  = d;
            end
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {out_valid, parity_err, frame_err, overrun});
        end
        checks++;
        if (out_data !== 8'h00) begin
            failures++; $display("FAIL reset_data got=%h want=00", out_data);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
        end
        checks++;
        if ({out_valid2, out_data2} !== 9'd0) begin
            failures++; $display("FAIL reset_np got=%h want=000", {out_valid2, out_data2});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    task automatic test_good_frame;
        send_frame(8'hA5, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL good_early got=%b want=0", out_valid);
        end
        finish_frame;
        model_frame(8'hA5, 0, 0, 0);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== {m_valid, e_par, e_frm, e_ovr}) begin
            failures++;
            $display("FAIL good_flags got=%b want=%b", {out_valid, parity_err, frame_err, overrun},
                     {m_valid, e_par, e_frm, e_ovr});
        end
        checks++;
        if (out_data !== m_data) begin
            failures++; $display("FAIL good_data got=%h want=%h", out_data, m_data);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== 4'b1000) begin
            failures++;
            $display("FAIL good_hold got=%b want=1000", {out_valid, parity_err, frame_err, overrun});
        end
        do_pop;
        m_valid = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {m_valid, m_data}) begin
            failures++;
            $display("FAIL good_pop got=%h want=%h", {out_valid, out_data}, {m_valid, m_data});
        end
    endtask

    task automatic test_parity_err;
        send_frame(8'hA5, 1, 0, 0, 0);
        finish_frame;
        model_frame(8'hA5, 1, 0, 0);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== {m_valid, e_par, e_frm, e_ovr}) begin
            failures++;
            $display("FAIL parity_flags got=%b want=%b", {out_valid, parity_err, frame_err, overrun},
                     {m_valid, e_par, e_frm, e_ovr});
        end
        @(negedge clk);
        checks++;
        if (parity_err !== 1'b0) begin
            failures++; $display("FAIL parity_pulse_len got=%b want=0", parity_err);
        end
    endtask

    task automatic test_frame_err;
        send_frame(8'hA5, 0, 1, 0, 0);
        finish_frame;
        model_frame(8'hA5, 0, 1, 0);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== {m_valid, e_par, e_frm, e_ovr}) begin
            failures++;
            $display("FAIL frame_flags got=%b want=%b", {out_valid, parity_err, frame_err, overrun},
                     {m_valid, e_par, e_frm, e_ovr});
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++; $display("FAIL frame_state got=%0d want=%0d", dbg_state, IDLE);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            failures++; $display("FAIL frame_pulse_len got=%b want=0", frame_err);
        end
        send_frame(8'h3C, 0, 0, 0, 0);
        finish_frame;
        model_frame(8'h3C, 0, 0, 0);
        checks++;
        if ({out_valid, out_data} !== {m_valid, m_data}) begin
            failures++;
            $display("FAIL frame_recover got=%h want=%h", {out_valid, out_data}, {m_valid, m_data});
        end
    endtask

    // Expects 0x3C still held from test_frame_err.
    task automatic test_overrun;
        send_frame(8'h81, 0, 0, 0, 0);
        finish_frame;
        model_frame(8'h81, 0, 0, 0);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== {m_valid, e_par, e_frm, e_ovr}) begin
            failures++;
            $display("FAIL overrun_flags got=%b want=%b", {out_valid, parity_err, frame_err, overrun},
                     {m_valid, e_par, e_frm, e_ovr});
        end
        checks++;
        if (out_data !== m_data) begin
            failures++; $display("FAIL overrun_data got=%h want=%h", out_data, m_data);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            failures++; $display("FAIL overrun_pulse_len got=%b want=0", overrun);
        end
        do_pop;
        m_valid = 1'b0;
        checks++;
        if (out_valid !== m_valid) begin
            failures++; $display("FAIL overrun_pop got=%b want=%b", out_valid, m_valid);
        end
    endtask

    task automatic test_pop_push;
        send_frame(8'h3C, 0, 0, 0, 0);
        finish_frame;
        model_frame(8'h3C, 0, 0, 0);
        send_frame(8'h81, 0, 0, 0, 1);
        finish_frame;
        model_frame(8'h81, 0, 0, 1);
        checks++;
        if ({out_valid, parity_err, frame_err, overrun} !== {m_valid, e_par, e_frm, e_ovr}) begin
            failures++;
            $display("FAIL poppush_flags got=%b want=%b", {out_valid, parity_err, frame_err, overrun},
                     {m_valid, e_par, e_frm, e_ovr});
        end
        checks++;
        if (out_data !== m_data) begin
            failures++; $display("FAIL poppush_data got=%h want=%h", out_data, m_data);
        end
        do_pop;
        m_valid = 1'b0;
    endtask

    task automatic test_gapped;
        logic [7:0] d;
        bit         pf, sv;
        for (int n = 0; n < 8; n++) begin
            d  = (n == 0) ? 8'h5A : 8'($urandom);
            pf = (n != 0) && ($urandom_range(3, 0) == 0);
            sv = (n != 0) && ($urandom_range(4, 0) == 0);
            send_frame(d, pf, sv, 3, 0);
            finish_frame;
            model_frame(d, pf, sv, 0);
            checks++;
            if ({out_valid, parity_err, frame_err, overrun} !== {m_valid, e_par, e_frm, e_ovr}) begin
                failures++;
                $display("FAIL gapped_flags[%0d] got=%b want=%b", n,
                         {out_valid, parity_err, frame_err, overrun}, {m_valid, e_par, e_frm, e_ovr});
            end
            checks++;
            if (out_data !== m_data) begin
                failures++; $display("FAIL gapped_data[%0d] got=%h want=%h", n, out_data, m_data);
            end
            if (m_valid) begin
                do_pop;
                m_valid = 1'b0;
            end
        end
    endtask

    // Frames with no idle gap, consumer always ready; bad-stop frames check
    // that the following start bit is still found.
    task automatic test_back_to_back;
        int n_frames = 10;
        int exp_err  = 0;
        int seen_err = 0;
        ready_level = 1'b1;
        exp_q.delete();
        fork
            begin
                logic [7:0] d;
                bit         pf, sv;
                for (int n = 0; n < n_frames; n++) begin
                    d  = 8'($urandom);
                    pf = ($urandom_range(4, 0) == 0);
                    sv = ($urandom_range(3, 0) == 0);
                    if (!pf && !sv) exp_q.push_back(d);
                    else exp_err++;
                    send_frame(d, pf, sv, 0, 0);
                end
                finish_frame;
            end
            begin
                logic [7:0] w;
                for (int c = 0; c < n_frames * 11 + 6; c++) begin
                    @(negedge clk);
                    if (parity_err || frame_err) seen_err++;
                    if (out_valid) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++; $display("FAIL b2b_extra got=%h want=none", out_data);
                        end else begin
                            w = exp_q.pop_front();
                            if (out_data !== w) begin
                                failures++; $display("FAIL b2b_data got=%h want=%h", out_data, w);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_missing got=%0d want=0", exp_q.size());
        end
        checks++;
        if (seen_err != exp_err) begin
            failures++; $display("FAIL b2b_errors got=%0d want=%0d", seen_err, exp_err);
        end
        ready_level = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        m_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'h66, 0, 0, 0, 0);
        finish_frame;
        model_frame(8'h66, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, parity_err, frame_err, overrun, out_data} !== 12'h000) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=000", {out_valid, parity_err, frame_err, overrun, out_data});
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++; $display("FAIL midreset_state got=%0d want=%0d", dbg_state, IDLE);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        send_frame(8'h0F, 0, 0, 0, 0);
        finish_frame;
        model_frame(8'h0F, 0, 0, 0);
        checks++;
        if ({out_valid, out_data} !== {m_valid, m_data}) begin
            failures++;
            $display("FAIL midreset_frame got=%h want=%h", {out_valid, out_data}, {m_valid, m_data});
        end
        do_pop;
        m_valid = 1'b0;
    endtask

    task automatic test_no_parity;
        logic [7:0] d = 8'h0F;
        drive2(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive2(1'b1, d[i]);
        @(negedge clk);
        checks++;
        if (out_valid2 !== 1'b0) begin
            failures++; $display("FAIL np_early got=%b want=0", out_valid2);
        end
        drive2(1'b1, 1'b0);
        drive2(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid2, parity_err2, frame_err2, overrun2, out_data2} !== {4'b1000, 8'h0F}) begin
            failures++;
            $display("FAIL np_frame got=%h want=%h", {out_valid2, parity_err2, frame_err2, overrun2, out_data2},
                     {4'b1000, 8'h0F});
        end
        d = 8'($urandom);
        drive2(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive2(1'b1, d[i]);
        drive2(1'b1, 1'b1);
        drive2(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid2, frame_err2, overrun2, out_data2} !== {3'b110, 8'h0F}) begin
            failures++;
            $display("FAIL np_stop_err got=%h want=%h", {out_valid2, frame_err2, overrun2, out_data2},
                     {3'b110, 8'h0F});
        end
    endtask

    // --------------------------------------------------------------- main
    initial begin
        rst_n       = 1'b0;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        out_ready   = 1'b0;
        bit_in2     = 1'b0;
        bit_valid2  = 1'b0;
        out_ready2  = 1'b0;
        ready_level = 1'b0;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        e_par       = 1'b0;
        e_frm       = 1'b0;
        e_ovr       = 1'b0;

        test_reset;
        test_good_frame;
        test_parity_err;
        test_frame_err;
        test_overrun;
        test_pop_push;
        test_gapped;
        test_back_to_back;
        test_reset_mid_frame;
        test_no_parity;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_frame_rx

// File: doc/serial_frame_rx.md
# serial_frame_rx

- Downstream consumer of the 4-bit serial shift stage.
- Samples the shift stage's serial output bit stream under a per-bit strobe and decodes framed words: start bit, DATA_W data bits LSB first, optional even-parity bit, stop bit.
- Presents decoded words on a valid/ready output holding register and flags parity, framing and overrun errors.

## Interface
Parameters:
- DATA_W, default 8: data bits per frame (2..16).
- PARITY_EN, default 1: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial bit from the upstream shift stage's serial output.
- bit_valid  input  1  qualifies bit_in; one bit is consumed per cycle with bit_valid=1.
- out_data  output  DATA_W  decoded word; stable while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word when out_valid&&out_ready.
- parity_err  output  1  one-cycle pulse: frame discarded for bad parity.
- frame_err  output  1  one-cycle pulse: frame discarded for bad stop bit.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

## Operation
- Frame format: start=1, data LSB first, parity (if PARITY_EN), stop=0.
- Even parity: XOR of the data bits and the parity bit must be 0.
- FSM states: IDLE, DATA, PARITY, STOP. State changes only on cycles with bit_valid=1; the FSM holds on bit_valid=0.
- IDLE: bit_in=1 -> DATA, bit counter cleared. bit_in=0 is ignored (line idle).
- DATA: shift bit_in into the word at position count, then increment count. After bit DATA_W-1 -> PARITY if PARITY_EN, else STOP.
- PARITY: latch the parity check result -> STOP.
- STOP, always -> IDLE:
  - bit_in=0 with parity OK -> frame good.
  - bit_in=1 -> frame_err pulse, frame discarded. This bit is not reinterpreted as a start bit.
  - bit_in=0 with parity bad -> parity_err pulse, frame discarded.
  - frame_err takes priority over parity_err; at most one error pulse per frame.
- Good frame, holding register empty or popping this cycle (out_ready=1): load out_data, out_valid=1.
- Good frame, out_valid=1 and out_ready=0: drop the new frame, pulse overrun. out_data is unchanged.
- Simultaneous pop and good-frame push: the old word is accepted, the new word is loaded, out_valid stays 1 with no gap.
- Pop alone: out_valid=0 next cycle. out_data keeps its last value.

## Timing
- Reset values: state IDLE, counter 0, out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0.
- Reset mid-frame: the partial frame is lost and any held word is cleared.
- Latency: out_valid rises on the cycle after the clock edge that samples the stop bit. The error and overrun pulses share that timing and last exactly one cycle.
- A complete frame takes exactly 2+DATA_W+PARITY_EN valid bits. Back-to-back frames (start bit immediately after stop) are supported at one bit per cycle.
- out_data, out_valid and all flags are registered; no combinational path from inputs to outputs.

## Structure
- Package serial_frame_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), START_BIT=1'b1, STOP_BIT=1'b0 constants.
- Counter width is $clog2(DATA_W) in the module.
- One sub-module: frame_out_reg, the valid/ready holding register with push/pop/overrun logic.
- Framing FSM and data shifter stay in serial_frame_rx.

## Test plan
- Good frame, DATA_W=8, PARITY_EN=1, bit_valid held 1: drive bits 1, 1,0,1,0,0,1,0,1, 0, 0 (start, 0xA5 LSB first, parity 0, stop) -> out_data=0xA5, out_valid=1 one cycle after stop; no error pulses.
- Same 0xA5 frame with parity bit 1 -> single parity_err pulse; out_valid stays 0. Same frame with stop bit 1 -> single frame_err pulse, FSM in IDLE; next 0x3C frame is decoded correctly.
- Overrun: out_ready=0, send 0x3C then 0x81 -> out_data stays 0x3C, one overrun pulse at the 0x81 stop. Raise out_ready -> 0x3C accepted, out_valid=0.
- Simultaneous pop/push: out_valid=1 holding 0x3C, out_ready=1 on the stop-sample cycle of 0x81 -> next cycle out_data=0x81, out_valid=1, no overrun.
- Gapped strobe: frame 0x5A with 0-3 random bit_valid=0 cycles between bits -> out_data=0x5A; bit_in toggling while bit_valid=0 has no effect.
- Reset mid-frame: rst_n low after 4 data bits of 0xF0 -> all outputs 0 immediately. After release, frame 0x0F -> out_data=0x0F. PARITY_EN=0 build decodes 0x0F with a 10-bit frame.
